pixel_plot_fifo: RTL and testbench

Clipping pixel buffer between the drawing engines (fillscreen, circle, future shape engines) and the VGA adapter. Engines push signed pixel coordinates through a valid/ready handshake; the block discards off-screen pixels, buffers on-screen ones in a small FIFO, and drains them to the adapter's x/y/colour/plot inputs at up to one pixel per cycle. A `done` level marks that the engine's final pixel has been written, so the top-level sequencer can start the next engine.

---
 rtl/pixel_plot_fifo.sv | 154 +++++++++++++++
 tb/tb_pixel_plot_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_plot_fifo.sv
// Clipping pixel buffer between the drawing engines and the VGA adapter.
// Define PIXEL_PLOT_FIFO_CLIP_EN to discard off-screen pixels; otherwise coordinates are truncated.
module pixel_plot_fifo #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_x,
    input  logic [8:0]  in_y,
    input  logic [2:0]  in_colour,
    input  logic        in_last,
    input  logic        out_en,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        done,
    output logic [15:0] clip_count,
    output logic [15:0] plot_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshake: a pixel transfers on a rising edge where in_valid && in_ready;
    // in_ready never depends on in_valid.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [18:0]   mem [DEPTH];
    logic [18:0]   head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          accept;
    logic          clipped;
    logic          push;
    logic          pop;
    logic          last_clipped;
    logic          last_popped;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !rst && !full && (state != DRAIN);
    assign accept   = in_valid && in_ready;
    assign push     = accept && !clipped;
    assign pop      = !empty && out_en;
    assign head     = mem[rd_ptr];
    assign done     = (state == DONE);

`ifdef PIXEL_PLOT_FIFO_CLIP_EN
    // Negative values have the sign bit set, so they are caught before the upper-bound compare.
    assign clipped = in_x[9] || (in_x >= 10'(SCREEN_W)) ||
                     in_y[8] || (in_y >= 9'(SCREEN_H));

    always_ff @(posedge clk) begin
        if (rst) begin
            clip_count <= '0;
        end else if (accept && clipped && (clip_count != 16'hFFFF)) begin
            clip_count <= clip_count + 16'd1;
        end
    end
`else
    assign clipped    = 1'b0;
    assign clip_count = '0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_x[7:0], in_y[6:0], in_colour, in_last};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            vga_x        <= '0;
            vga_y        <= '0;
            vga_colour   <= '0;
            vga_plot     <= 1'b0;
            plot_count   <= '0;
            last_clipped <= 1'b0;
            last_popped  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                vga_x      <= head[18:11];
                vga_y      <= head[10:4];
                vga_colour <= head[3:1];
            end
            vga_plot <= pop;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop && (plot_count != 16'hFFFF)) begin
                plot_count <= plot_count + 16'd1;
            end
            // A last-flagged entry is always the newest in the FIFO and nothing is
            // accepted in DRAIN, so these two updates never coincide.
            if (accept) begin
                last_clipped <= clipped && in_last;
                last_popped  <= 1'b0;
            end else if (pop && head[0]) begin
                last_popped <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACTIVE, DONE: begin
                if (accept) begin
                    state_next = in_last ? DRAIN : ACTIVE;
                end
            end
            DRAIN: begin
                if (empty && (last_popped || last_clipped)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pixel_plot_fifo.sv
// Directed bench for pixel_plot_fifo: stimulus pushes expected pixels into a queue,
// a negedge monitor pops and compares on every vga_plot cycle.
module tb_pixel_plot_fifo;

`ifdef PIXEL_PLOT_FIFO_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  in_x = '0;
    logic [8:0]  in_y = '0;
    logic [2:0]  in_colour = '0;
    logic        in_last = 1'b0;
    logic        out_en = 1'b0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        done;
    logic [15:0] clip_count;
    logic [15:0] plot_count;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [17:0] exp_q[$];
    int          exp_plot = 0;
    int          exp_clip = 0;
    int          run_len = 0;
    int          last_run = 0;
    logic [17:0] mon_exp;

    pixel_plot_fifo dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_last(in_last),
        .out_en(out_en),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .done(done), .clip_count(clip_count), .plot_count(plot_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit off_screen(input logic signed [9:0] x, input logic signed [8:0] y);
        bit oob;
        oob = (x < 0) || (x >= 160) || (y < 0) || (y >= 120);
        return CLIP_EN && oob;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (vga_plot === 1'b1) begin
            run_len++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, expected no plot",
                         vga_x, vga_y, vga_colour);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({vga_x, vga_y, vga_colour} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL plot_data: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                             vga_x, vga_y, vga_colour, mon_exp[17:10], mon_exp[9:3], mon_exp[2:0]);
                end
            end
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
        end
    end

    // ---------------- drivers ----------------
    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic push(input logic signed [9:0] x, input logic signed [8:0] y,
                        input logic [2:0] c, input logic last, output int waited);
        in_valid  = 1'b1;
        in_x      = x;
        in_y      = y;
        in_colour = c;
        in_last   = last;
        waited    = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL push_timeout: got in_ready=%0d, expected 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (off_screen(x, y)) begin
                exp_clip++;
            end else begin
                exp_q.push_back({x[7:0], y[6:0], c});
                exp_plot++;
            end
        end
    endtask

    task automatic wait_done(input string name, input bit exp_prev_plot);
        bit   found;
        logic prev;
        found = 0;
        prev  = 1'b0;
        check({name, "_done_low"}, done, 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1;
                break;
            end
            prev = vga_plot;
        end
        check({name, "_done_rise"}, found, 1);
        if (found) check({name, "_plot_before_done"}, prev, exp_prev_plot);
    endtask

    task automatic check_counts(input string name);
        check({name, "_plot_count"}, plot_count, exp_plot);
        check({name, "_clip_count"}, clip_count, exp_clip);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int total_wait;
        int accepted;

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_vga_plot", vga_plot, 0);
        check("rst_done", done, 0);
        check("rst_vga_xy", {vga_x, vga_y, vga_colour}, 0);
        check_counts("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // single pixel, exact latency
        out_en = 1'b1;
        push(10'sd80, 9'sd60, 3'b010, 1'b1, w);
        @(negedge clk);
        check("t1_plot_cycle0", vga_plot, 0);
        @(negedge clk);
        check("t1_plot_cycle1", vga_plot, 1);
        check("t1_x", vga_x, 80);
        check("t1_y", vga_y, 60);
        check("t1_colour", vga_colour, 2);
        check("t1_done_early", done, 0);
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_plot_off", vga_plot, 0);
        check("t1_plot_count", plot_count, 1);
        @(posedge clk); #1;

        // clipping vectors
        push(-10'sd1, 9'sd10, 3'd1, 1'b0, w);
        push(10'sd160, 9'sd10, 3'd2, 1'b0, w);
        push(10'sd5, -9'sd3, 3'd3, 1'b0, w);
        push(10'sd5, 9'sd120, 3'd4, 1'b0, w);
        push(10'sd159, 9'sd119, 3'd5, 1'b1, w);
        wait_done("t2", 1'b1);
        @(negedge clk);
        check_counts("t2");
        @(posedge clk); #1;

        // fill with out_en low, then drain; twice to exercise pointer wrap
        for (int pass = 0; pass < 2; pass++) begin
            out_en   = 1'b0;
            accepted = 0;
            for (int i = 0; i < 10; i++) begin
                if (in_ready !== 1'b1) break;
                push(10'(pass * 90 + i * 7), 9'(3 + i * 5 + pass), 3'(i + pass), 1'b0, w);
                accepted++;
            end
            check("fill_accepted", accepted, 8);
            check("fill_full_ready", in_ready, 0);
            out_en = 1'b1;
            repeat (11) @(negedge clk);
            check("fill_drain_run", last_run, 8);
            check_counts("fill");
            @(posedge clk); #1;
        end

        // last pixel blocks further acceptance while draining
        out_en = 1'b0;
        push(10'sd10, 9'sd10, 3'd1, 1'b1, w);
        check("drain_ready_low", in_ready, 0);
        out_en = 1'b1;
        wait_done("t3", 1'b1);
        @(posedge clk); #1;

        // streaming 20 pixels; the last one is off-screen
        total_wait = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 19) push(10'sd200, 9'sd5, 3'd7, 1'b1, w);
            else         push(10'(i * 8), 9'(i * 6), 3'(i), 1'b0, w);
            total_wait += w;
        end
        check("stream_stalls", total_wait, 0);
        wait_done("stream", 1'b1);
        @(negedge clk);
        check("stream_run", last_run, CLIP_EN ? 19 : 20);
        check_counts("stream");
        @(posedge clk); #1;

        // reset with 5 buffered entries
        out_en = 1'b0;
        for (int i = 0; i < 5; i++) push(10'(30 + i), 9'(40 + i), 3'(i), 1'b0, w);
        rst    = 1'b1;
        out_en = 1'b1;
        @(negedge clk);
        check("rst_mid_plot", vga_plot, 0);
        check("rst_mid_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_plot = 0;
        exp_clip = 0;
        @(negedge clk);
        check("rst_mid_ready_after", in_ready, 1);
        check("rst_mid_done", done, 0);
        check_counts("rst_mid");
        repeat (5) @(negedge clk);
        check("rst_mid_no_plot", vga_plot, 0);
        @(posedge clk); #1;
        push(10'sd20, 9'sd20, 3'd6, 1'b1, w);
        wait_done("rst_mid", 1'b1);
        @(posedge clk); #1;

        // x beyond the screen width
        push(10'sd165, 9'sd10, 3'd5, 1'b1, w);
        wait_done("wide", !CLIP_EN);
        @(negedge clk);
        check_counts("wide");

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
